// File: rtl/regfile_wr_decoder_pkg.sv
// Shared types and default sizing for the register-file write-wordline decoder.
package regfile_dec_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_LEN_W  = DEF_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } dec_state_e;

endpackage

// File: rtl/regfile_wr_decoder_if.sv
// Write-request handshake bundle between issue/write-back logic and the wordline decoder.
interface regfile_wr_decoder_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = ADDR_W
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_wrap;

    modport master (
        output req_valid,
        output req_addr,
        output req_len,
        output req_wrap,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_len,
        input  req_wrap,
        output req_ready
    );

endinterface

// File: rtl/regfile_wr_decoder_onehot.sv
// Combinational binary-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_decoder #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   en_i,
    input  logic [ADDR_W-1:0]      idx_i,
    output logic [(2**ADDR_W)-1:0] onehot_o
);

    // Single set bit at idx_i when enabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_decoder.sv
// Registered ADDR_W:2^ADDR_W write-wordline decoder with single/burst requests.
// One one-hot wordline per beat, auto-incrementing index, abort and truncation reporting.
// Optional macro REGFILE_ZERO_GUARD_EN: wordline 0 is never driven (hard-zero register),
// though a beat targeting index 0 still takes its cycle.
module regfile_wr_decoder
    import regfile_dec_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN_W  = ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_wr_decoder_if.slave    req,
    input  logic                   abort,
    output logic [(2**ADDR_W)-1:0] wl_en,
    output logic [ADDR_W-1:0]      wl_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err_trunc
);

    localparam int unsigned  NUM_OUT  = 2**ADDR_W;
    localparam logic [LEN_W:0] ONE_BEAT = {{LEN_W{1'b0}}, 1'b1};

    dec_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    // Beats still to be issued, counting the one currently on the wordlines
    logic [LEN_W:0]       rem_q, rem_d;
    logic                 wrap_q, wrap_d;
    // done_q marks the displayed beat as the last one of its burst
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [NUM_OUT-1:0]   wl_en_q;
    logic [NUM_OUT-1:0]   dec_out;
    logic                 beat_d;
    logic                 dec_en;
    logic                 accept;
    logic                 single;
    logic                 at_top_req;
    logic                 at_top_nxt;

    // A new request may enter when idle or during the final beat, unless aborting
    assign req.req_ready = !abort && ((state_q == IDLE) || done_q);
    assign accept        = req.req_valid && req.req_ready;

    assign single     = (req.req_len == '0);
    assign at_top_req = &req.req_addr;

    // Next-state, next-beat index and last/truncation flags for the beat being loaded
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        wrap_d     = wrap_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        beat_d     = 1'b0;
        at_top_nxt = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = BURST;
            beat_d  = 1'b1;
            idx_d   = req.req_addr;
            rem_d   = {1'b0, req.req_len} + ONE_BEAT;
            wrap_d  = req.req_wrap;
            done_d  = single || (!req.req_wrap && at_top_req);
            err_d   = !single && !req.req_wrap && at_top_req;
        end else if ((state_q == BURST) && !done_q) begin
            beat_d     = 1'b1;
            idx_d      = idx_q + 1'b1;
            rem_d      = rem_q - ONE_BEAT;
            at_top_nxt = &idx_d;
            done_d     = (rem_d == ONE_BEAT) || (!wrap_q && at_top_nxt);
            err_d      = (rem_d != ONE_BEAT) && !wrap_q && at_top_nxt;
        end else begin
            state_d = IDLE;
        end
    end

`ifdef REGFILE_ZERO_GUARD_EN
    assign dec_en = beat_d && (idx_d != '0);
`else
    assign dec_en = beat_d;
`endif

    onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_onehot (
        .en_i     (dec_en),
        .idx_i    (idx_d),
        .onehot_o (dec_out)
    );

    // State and output registers; reset overrides any in-flight burst or accept
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_en_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wl_en_q <= dec_out;
        end
    end

    assign wl_en     = wl_en_q;
    assign wl_idx    = idx_q;
    assign busy      = (state_q == BURST);
    assign done      = done_q;
    assign err_trunc = err_q;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Self-checking bench for regfile_wr_decoder: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-of-beats reference model.
module tb_regfile_wr_decoder;

    localparam int unsigned AW = 5;
    localparam int unsigned LW = 5;
    localparam int          N  = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        abort;
    logic [31:0] wl_en;
    logic [4:0]  wl_idx;
    logic        busy;
    logic        done;
    logic        err_trunc;

    regfile_wr_decoder_if #(.ADDR_W(AW), .LEN_W(LW)) req_if ();

    regfile_wr_decoder #(
        .ADDR_W (AW),
        .LEN_W  (LW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_if.slave),
        .abort     (abort),
        .wl_en     (wl_en),
        .wl_idx    (wl_idx),
        .busy      (busy),
        .done      (done),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] idx;
        logic       last;
        logic       trunc;
    } beat_t;

    beat_t pend[$];
    beat_t cur;
    bit    cur_v;
    bit    idx_known;
    bit    exp_ready;
    int    vec_cnt;
    int    err_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand a request into the full list of beats it should produce
    task automatic push_burst(input int a, input int l, input bit w);
        int beats;
        bit tr;
        beat_t b;
        beats = l + 1;
        tr    = 1'b0;
        if (!w && (a + l > N - 1)) begin
            beats = N - a;
            tr    = 1'b1;
        end
        for (int k = 0; k < beats; k++) begin
            b.idx   = 5'((a + k) % N);
            b.last  = (k == beats - 1);
            b.trunc = (k == beats - 1) && tr;
            pend.push_back(b);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check registered outputs
    task automatic step(input logic v, input logic [4:0] a, input logic [4:0] l,
                        input logic w, input logic ab, input logic rn);
        logic [31:0] exp_en;
        @(negedge clk);
        req_if.req_valid = v;
        req_if.req_addr  = a;
        req_if.req_len   = l;
        req_if.req_wrap  = w;
        abort            = ab;
        reset_n          = rn;
        #1;
        exp_ready = !ab && (!cur_v || (pend.size() == 0));
        check_eq("req_ready", req_if.req_ready, exp_ready);
        @(posedge clk);
        idx_known = 1'b0;
        if (!rn) begin
            pend.delete();
            cur_v     = 1'b0;
            cur       = '0;
            idx_known = 1'b1;
        end else if (ab) begin
            pend.delete();
            cur_v = 1'b0;
        end else if (v && exp_ready) begin
            pend.delete();
            push_burst(int'(a), int'(l), w);
            cur   = pend.pop_front();
            cur_v = 1'b1;
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else begin
            cur_v = 1'b0;
        end
        #1;
        exp_en = '0;
        if (cur_v) exp_en = 32'h1 << cur.idx;
`ifdef REGFILE_ZERO_GUARD_EN
        if (cur_v && cur.idx == 5'd0) exp_en = '0;
`endif
        check_eq("wl_en", wl_en, exp_en);
        check_eq("busy", busy, cur_v);
        check_eq("done", done, cur_v && cur.last);
        check_eq("err_trunc", err_trunc, cur_v && cur.trunc);
        if (cur_v || idx_known) check_eq("wl_idx", wl_idx, cur.idx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic       rv, rw, rab, rrn;
        logic [4:0] ra, rl;
        vec_cnt          = 0;
        err_cnt          = 0;
        cur_v            = 1'b0;
        cur              = '0;
        idx_known        = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_len   = '0;
        req_if.req_wrap  = 1'b0;
        abort            = 1'b0;
        reset_n          = 1'b0;
        repeat (2) @(posedge clk);

        // 1: reset held with a valid request pending, then release
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        check_eq("t1_wl_en", wl_en, 32'h0);
        idle(1);

        // 2: single write to index 7
        step(1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
        check_eq("t2_wl_en", wl_en, 32'h0000_0080);
        check_eq("t2_done", done, 1'b1);
        idle(1);
        check_eq("t2_idle", busy, 1'b0);

        // 3: wrapping burst across the top
        step(1'b1, 5'd30, 5'd3, 1'b1, 1'b0, 1'b1);
        idle(3);
        check_eq("t3_last_idx", wl_idx, 5'd1);
        idle(1);

        // 4: non-wrapping burst truncated at the top index
        step(1'b1, 5'd29, 5'd5, 1'b0, 1'b0, 1'b1);
        idle(2);
        check_eq("t4_err", err_trunc, 1'b1);
        idle(1);
        check_eq("t4_idle", busy, 1'b0);

        // 5: back-to-back requests, second held valid until taken on the last beat
        step(1'b1, 5'd4, 5'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_idx10", wl_idx, 5'd10);
        idle(2);

        // 6: abort, then reset, at beat 2 of an 8-beat burst
        step(1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 7: full-length burst
        step(1'b1, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1);
        idle(33);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            ra  = ($urandom_range(0, 3) == 0) ? 5'(27 + $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
            rl  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            rab = ($urandom_range(0, 15) == 0);
            rrn = ($urandom_range(0, 63) != 0);
            step(rv, ra, rl, rw, rab, rrn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
